// File: rtl/fhe_kernel_rr_scheduler.sv
// Round-robin scheduler that time-shares one external combinational bit-manipulation kernel.
// Optional macro FHE_SCHED_BACK2BACK_EN: take the next grant on the response handshake edge, skipping IDLE.
module fhe_kernel_rr_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 2,
  parameter int KERNEL_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         kern_x,
  input  logic [DATA_W-1:0]         kern_y,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy
);

  localparam int CNT_W = $clog2(KERNEL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KERNEL_LAT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [CNT_W-1:0]  cnt;
  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic [DATA_W-1:0] gnt_data;
  logic              accept;

  // Scan from farthest to nearest so the requester closest after ptr wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  assign gnt_data = req_data[int'(gnt_idx)*DATA_W +: DATA_W];

`ifdef FHE_SCHED_BACK2BACK_EN
  assign accept = gnt_found && ((state == IDLE) || ((state == RESP) && rsp_ready));
`else
  assign accept = gnt_found && (state == IDLE);
`endif

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[int'(gnt_idx)] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  // Accept loads the operand, then count KERNEL_LAT edges before sampling kern_y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      kern_x    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      cnt       <= '0;
      ptr       <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            kern_x <= gnt_data;
            rsp_id <= gnt_idx;
            ptr    <= gnt_idx;
            cnt    <= CNT_W'(1);
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            rsp_data  <= kern_y;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
            if (accept) begin
              kern_x <= gnt_data;
              rsp_id <= gnt_idx;
              ptr    <= gnt_idx;
              cnt    <= CNT_W'(1);
              state  <= WAIT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

  a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_id)));

endmodule

// File: tb/tb_fhe_kernel_rr_scheduler.sv
// Self-checking bench for fhe_kernel_rr_scheduler with a transaction-level reference model and kern_y = ~kern_x stub.
module tb_fhe_kernel_rr_scheduler;
  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 32;
  localparam int ID_W       = 2;
  localparam int KERNEL_LAT = 2;
`ifdef FHE_SCHED_BACK2BACK_EN
  localparam int SPACING = KERNEL_LAT + 1;
`else
  localparam int SPACING = KERNEL_LAT + 2;
`endif

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         kern_x;
  logic [DATA_W-1:0]         kern_y;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic [ID_W-1:0]           rsp_id;
  logic                      busy;

  fhe_kernel_rr_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W), .KERNEL_LAT(KERNEL_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .kern_x(kern_x), .kern_y(kern_y), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign kern_y = ~kern_x;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit cmpEn = 1'b0;

  // Reference model: a transaction is either absent, ageing toward capture, or awaiting handshake.
  bit          mBusy  = 1'b0;
  bit          mResp  = 1'b0;
  int          mAge   = 0;
  logic [31:0] mX     = '0;
  logic [31:0] mRdata = '0;
  int          mId    = 0;
  int          mPtr   = NUM_REQ - 1;
  int          glogId[$];
  int          glogCyc[$];

  function automatic int findGrant(input int p, input logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic void takeGrant(input int g);
    mX    = req_data[g*DATA_W +: DATA_W];
    mId   = g;
    mPtr  = g;
    mBusy = 1'b1;
    mResp = 1'b0;
    mAge  = 0;
    glogId.push_back(g);
    glogCyc.push_back(cyc);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int g;
    if (!rst_n) begin
      mBusy = 1'b0; mResp = 1'b0; mAge = 0;
      mX = '0; mRdata = '0; mId = 0; mPtr = NUM_REQ - 1;
    end else begin
      cyc++;
      g = findGrant(mPtr, req_valid);
      if (!mBusy) begin
        if (g >= 0) takeGrant(g);
      end else if (!mResp) begin
        mAge++;
        if (mAge == KERNEL_LAT) begin
          mResp  = 1'b1;
          mRdata = ~mX;
        end
      end else if (rsp_ready) begin
        mResp = 1'b0;
        mBusy = 1'b0;
`ifdef FHE_SCHED_BACK2BACK_EN
        if (g >= 0) takeGrant(g);
`endif
      end
    end
  end

  function automatic logic [NUM_REQ-1:0] expReady();
    logic [NUM_REQ-1:0] r;
    int g;
    r = '0;
    g = findGrant(mPtr, req_valid);
    if (g >= 0 && !mBusy) r[g] = 1'b1;
`ifdef FHE_SCHED_BACK2BACK_EN
    if (g >= 0 && mResp && rsp_ready) r[g] = 1'b1;
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("cyc req_ready", 32'(req_ready), 32'(expReady()));
      checkOutput("cyc kern_x", kern_x, mX);
      checkOutput("cyc rsp_valid", 32'(rsp_valid), 32'(mResp));
      checkOutput("cyc rsp_data", rsp_data, mRdata);
      checkOutput("cyc rsp_id", 32'(rsp_id), 32'(mId));
      checkOutput("cyc busy", 32'(busy), 32'(mBusy));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*DATA_W-1:0] d);
    req_valid = v;
    req_data  = d;
  endtask

  task automatic waitResp();
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    if (!rsp_valid) checkOutput("waitResp timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((busy || rsp_valid) && n < 40) begin
      tick();
      n++;
    end
    if (busy) checkOutput("waitIdle timeout", 32'(busy), 32'd0);
  endtask

  task automatic resetPulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  localparam logic [127:0] OPS = {32'hA303_0303, 32'hA202_0202, 32'hA101_0101, 32'hA000_0000};
  localparam int EXP_ORDER [5] = '{0, 1, 2, 3, 0};

  initial begin
    int n;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    applyStimulus('0, '0);
    #12;
    checkOutput("reset kern_x", kern_x, 32'h0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rsp_data", rsp_data, 32'h0);
    checkOutput("reset rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    cmpEn = 1'b1;
    tick();

    // Single request with the documented F0 operand.
    applyStimulus(4'b0001, 128'h0000_00F0);
    #1;
    checkOutput("single req_ready", 32'(req_ready), 32'h1);
    tick();
    applyStimulus('0, 128'h0000_00F0);
    checkOutput("single kern_x", kern_x, 32'h0000_00F0);
    checkOutput("single busy", 32'(busy), 32'd1);
    tick();
    checkOutput("single early rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    checkOutput("single rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("single rsp_data", rsp_data, 32'hFFFF_FF0F);
    checkOutput("single rsp_id", 32'(rsp_id), 32'd0);
    tick();
    checkOutput("single done rsp_valid", 32'(rsp_valid), 32'd0);
    waitIdle();

    // All four requesting continuously from a fresh pointer.
    resetPulse();
    glogId.delete(); glogCyc.delete();
    applyStimulus(4'b1111, OPS);
    n = 0;
    while (glogId.size() < 5 && n < 60) begin
      tick();
      n++;
    end
    applyStimulus('0, OPS);
    waitIdle();
    checkOutput("rr grant count", 32'(glogId.size() >= 5), 32'd1);
    if (glogId.size() >= 5) begin
      for (int i = 0; i < 5; i++) checkOutput($sformatf("rr order %0d", i), 32'(glogId[i]), 32'(EXP_ORDER[i]));
      for (int i = 0; i < 4; i++) checkOutput($sformatf("rr spacing %0d", i), 32'(glogCyc[i+1] - glogCyc[i]), 32'(SPACING));
    end

    // Back-pressure on requester 1 while requester 3 waits.
    rsp_ready = 1'b0;
    applyStimulus(4'b0010, OPS);
    tick();
    applyStimulus(4'b1000, OPS);
    waitResp();
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp rsp_data", rsp_data, 32'h5EFE_FEFE);
      checkOutput("bp rsp_id", 32'(rsp_id), 32'd1);
      checkOutput("bp req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    applyStimulus('0, OPS);
    rsp_ready = 1'b1;
    tick();
    checkOutput("bp release rsp_valid", 32'(rsp_valid), 32'd0);
    waitIdle();

    // Operand changes after accept must not reach the kernel.
    applyStimulus(4'b0100, {32'h0, 32'h1234_5678, 64'h0});
    tick();
    applyStimulus('0, {32'h0, 32'hDEAD_BEEF, 64'h0});
    checkOutput("hold kern_x", kern_x, 32'h1234_5678);
    waitResp();
    checkOutput("hold rsp_data", rsp_data, 32'hEDCB_A987);
    checkOutput("hold rsp_id", 32'(rsp_id), 32'd2);
    tick();
    waitIdle();

    // Pointer sits at 2, so 0101 serves 0 then 2.
    glogId.delete(); glogCyc.delete();
    applyStimulus(4'b0101, OPS);
    n = 0;
    while (glogId.size() < 2 && n < 40) begin
      tick();
      n++;
    end
    applyStimulus('0, OPS);
    waitIdle();
    checkOutput("ptr grant count", 32'(glogId.size() >= 2), 32'd1);
    if (glogId.size() >= 2) begin
      checkOutput("ptr first", 32'(glogId[0]), 32'd0);
      checkOutput("ptr second", 32'(glogId[1]), 32'd2);
    end

    // Asynchronous reset while a transaction is in WAIT.
    applyStimulus(4'b1111, OPS);
    tick();
    checkOutput("ar busy before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar kern_x", kern_x, 32'h0);
    checkOutput("ar rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("ar busy", 32'(busy), 32'd0);
    checkOutput("ar rsp_id", 32'(rsp_id), 32'd0);
    glogId.delete(); glogCyc.delete();
    #3;
    rst_n = 1'b1;
    n = 0;
    while (glogId.size() < 1 && n < 10) begin
      tick();
      n++;
    end
    applyStimulus('0, OPS);
    checkOutput("ar grant count", 32'(glogId.size() >= 1), 32'd1);
    if (glogId.size() >= 1) checkOutput("ar first grant", 32'(glogId[0]), 32'd0);
    checkOutput("ar kern_x after", kern_x, 32'hA000_0000);
    waitIdle();
    tick();

    cmpEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
